// File: rtl/poker_game_seq.sv
// Game controller for the poker datapath: bet/deal, hold selection, draw,
// judge wait and payout into a saturating credit register.
module poker_game_seq #(
  parameter logic [15:0] BET           = 16'd1,
  parameter logic [15:0] INIT_CREDIT   = 16'd100,
  parameter logic [23:0] HOLD_TIMEOUT  = 24'd12_000_000,
  parameter logic [7:0]  JUDGE_TIMEOUT = 8'd255
) (
  input  logic        clock,
  input  logic        reset_c,
  input  logic        start_b,
  input  logic [4:0]  hold_b,
  input  logic        draw_b,
  input  logic        deck_ready,
  input  logic        pjudge,
  input  logic [3:0]  hand_rank,
  input  logic        rank_valid,
  output logic        deck_req,
  output logic        hold_o0,
  output logic        hold_o1,
  output logic        hold_o2,
  output logic        hold_o3,
  output logic        hold_o4,
  output logic        draw_s,
  output logic [15:0] credit,
  output logic [15:0] win,
  output logic [2:0]  state_o,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEAL   = 3'd1;
  localparam logic [2:0] S_HOLD   = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_JUDGE  = 3'd4;
  localparam logic [2:0] S_PAYOUT = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] credit_q, credit_d;
  logic [15:0] win_q, win_d;
  logic [4:0]  hold_q, hold_d;
  logic        draw_s_q, draw_s_d;
  logic        deck_req_q, deck_req_d;
  logic [23:0] hold_tmr_q, hold_tmr_d;
  logic [7:0]  judge_tmr_q, judge_tmr_d;
  logic [3:0]  rank_q, rank_d;
  logic [15:0] payout;
  logic        hold_expired;

  function automatic logic [6:0] mult(input logic [3:0] r);
    case (r)
      4'd2:    mult = 7'd1;
      4'd3:    mult = 7'd2;
      4'd4:    mult = 7'd3;
      4'd5:    mult = 7'd4;
      4'd6:    mult = 7'd10;
      4'd7:    mult = 7'd20;
      4'd8:    mult = 7'd50;
      4'd9:    mult = 7'd100;
      default: mult = 7'd0;
    endcase
  endfunction

  // Credit must never wrap back to a small value after a big win.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign payout       = BET * {9'd0, mult(rank_q)};
  assign hold_expired = (HOLD_TIMEOUT != 24'd0) && (hold_tmr_q == HOLD_TIMEOUT - 24'd1);

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    win_d       = win_q;
    hold_d      = hold_q;
    draw_s_d    = draw_s_q;
    deck_req_d  = deck_req_q;
    hold_tmr_d  = hold_tmr_q;
    judge_tmr_d = judge_tmr_q;
    rank_d      = rank_q;
    case (state_q)
      S_IDLE: begin
        if (start_b && (credit_q >= BET)) begin
          credit_d   = credit_q - BET;
          win_d      = 16'd0;
          hold_d     = 5'd0;
          deck_req_d = 1'b1;
          state_d    = S_DEAL;
        end
      end
      S_DEAL: begin
        if (deck_ready) begin
          deck_req_d = 1'b0;
          hold_tmr_d = 24'd0;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        // Toggles land on the same edge as a draw, so they are included in it.
        hold_d = hold_q ^ hold_b;
        if (draw_b || hold_expired) begin
          draw_s_d = 1'b1;
          state_d  = S_DRAW;
        end else begin
          hold_tmr_d = hold_tmr_q + 24'd1;
        end
      end
      S_DRAW: begin
        if (pjudge) begin
          draw_s_d    = 1'b0;
          judge_tmr_d = 8'd0;
          state_d     = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (rank_valid) begin
          rank_d  = hand_rank;
          state_d = S_PAYOUT;
        end else if (judge_tmr_q == JUDGE_TIMEOUT) begin
          rank_d  = 4'd0;
          state_d = S_PAYOUT;
        end else begin
          judge_tmr_d = judge_tmr_q + 8'd1;
        end
      end
      S_PAYOUT: begin
        win_d    = payout;
        credit_d = sat_add(credit_q, payout);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      state_q     <= S_IDLE;
      credit_q    <= INIT_CREDIT;
      win_q       <= 16'd0;
      hold_q      <= 5'd0;
      draw_s_q    <= 1'b0;
      deck_req_q  <= 1'b0;
      hold_tmr_q  <= 24'd0;
      judge_tmr_q <= 8'd0;
      rank_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      win_q       <= win_d;
      hold_q      <= hold_d;
      draw_s_q    <= draw_s_d;
      deck_req_q  <= deck_req_d;
      hold_tmr_q  <= hold_tmr_d;
      judge_tmr_q <= judge_tmr_d;
      rank_q      <= rank_d;
    end
  end

  assign deck_req = deck_req_q;
  assign draw_s   = draw_s_q;
  assign hold_o0  = hold_q[0];
  assign hold_o1  = hold_q[1];
  assign hold_o2  = hold_q[2];
  assign hold_o3  = hold_q[3];
  assign hold_o4  = hold_q[4];
  assign credit   = credit_q;
  assign win      = win_q;
  assign state_o  = state_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_HOLD);

endmodule

// File: tb/tb_poker_game_seq.sv
// Bench for poker_game_seq: directed games with literal checks plus a
// cycle-by-cycle comparison against a behavioural game model.
module tb_poker_game_seq;

  localparam int BET  = 1;
  localparam int INIT = 100;
  localparam int HT   = 20;
  localparam int JT   = 8;

  logic        clock = 1'b0;
  logic        reset_c = 1'b0;
  logic        start_b = 1'b0;
  logic [4:0]  hold_b = 5'd0;
  logic        draw_b = 1'b0;
  logic        deck_ready = 1'b0;
  logic        pjudge = 1'b0;
  logic [3:0]  hand_rank = 4'd0;
  logic        rank_valid = 1'b0;
  logic        deck_req, hold_o0, hold_o1, hold_o2, hold_o3, hold_o4, draw_s, busy;
  logic [15:0] credit, win;
  logic [2:0]  state_o;

  int n_chk = 0;
  int n_fail = 0;

  poker_game_seq #(
    .BET(16'd1), .INIT_CREDIT(16'd100), .HOLD_TIMEOUT(24'd20), .JUDGE_TIMEOUT(8'd8)
  ) dut (
    .clock(clock), .reset_c(reset_c), .start_b(start_b), .hold_b(hold_b),
    .draw_b(draw_b), .deck_ready(deck_ready), .pjudge(pjudge),
    .hand_rank(hand_rank), .rank_valid(rank_valid), .deck_req(deck_req),
    .hold_o0(hold_o0), .hold_o1(hold_o1), .hold_o2(hold_o2), .hold_o3(hold_o3),
    .hold_o4(hold_o4), .draw_s(draw_s), .credit(credit), .win(win),
    .state_o(state_o), .busy(busy)
  );

  initial forever #5 clock = ~clock;

  // Behavioural model: game phase, credits as plain integers.
  int MULT[16] = '{0, 0, 1, 2, 3, 4, 10, 20, 50, 100, 0, 0, 0, 0, 0, 0};
  int m_phase, m_credit, m_win, m_wait, m_rank;
  logic [4:0] m_hold;

  always @(posedge clock or negedge reset_c) begin
    if (!reset_c) begin
      m_phase = 0; m_credit = INIT; m_win = 0; m_hold = 5'd0; m_wait = 0; m_rank = 0;
    end else begin
      case (m_phase)
        0: if (start_b && m_credit >= BET) begin
             m_credit = m_credit - BET; m_win = 0; m_hold = 5'd0; m_phase = 1;
           end
        1: if (deck_ready) begin m_phase = 2; m_wait = 0; end
        2: begin
             m_hold = m_hold ^ hold_b;
             m_wait = m_wait + 1;
             if (draw_b || (HT != 0 && m_wait >= HT)) m_phase = 3;
           end
        3: if (pjudge) begin m_phase = 4; m_wait = 0; end
        4: begin
             m_wait = m_wait + 1;
             if (rank_valid) begin m_rank = int'(hand_rank); m_phase = 5; end
             else if (m_wait > JT) begin m_rank = 0; m_phase = 5; end
           end
        default: begin
             m_win = (BET * MULT[m_rank]) % 65536;
             m_credit = m_credit + m_win;
             if (m_credit > 65535) m_credit = 65535;
             m_phase = 0;
           end
      endcase
    end
  end

  logic [43:0] exp_v, act_v;
  always @(negedge clock) begin
    if (reset_c === 1'b1) begin
      exp_v = {3'(m_phase), !(m_phase == 0 || m_phase == 2), (m_phase == 1), (m_phase == 3),
               m_hold, 16'(m_credit), 16'(m_win)};
      act_v = {state_o, busy, deck_req, draw_s, hold_o4, hold_o3, hold_o2, hold_o1, hold_o0,
               credit, win};
      n_chk++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t dut=%h model=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic play_game(input int r, input logic [4:0] holds);
    start_b = 1'b1; cyc(1); start_b = 1'b0;
    deck_ready = 1'b1; cyc(1); deck_ready = 1'b0;
    hold_b = holds; draw_b = 1'b1; cyc(1); hold_b = 5'd0; draw_b = 1'b0;
    pjudge = 1'b1; cyc(1); pjudge = 1'b0;
    hand_rank = 4'(r); rank_valid = 1'b1; cyc(1); rank_valid = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    reset_c = 1'b0; cyc(2); reset_c = 1'b1; cyc(1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    do_reset();
    chk("rst_credit", int'(credit), 100);
    chk("rst_state", int'(state_o), 0);
    chk("rst_outs", int'({deck_req, draw_s, busy, hold_o4, hold_o3, hold_o2, hold_o1, hold_o0}), 0);
    chk("rst_win", int'(win), 0);

    start_b = 1'b1; cyc(1); start_b = 1'b0;
    chk("start_credit", int'(credit), 99);
    chk("start_req", int'(deck_req), 1);
    chk("start_state", int'(state_o), 1);
    cyc(2);
    chk("deal_wait_req", int'(deck_req), 1);
    deck_ready = 1'b1; cyc(1); deck_ready = 1'b0;
    chk("deal_done_req", int'(deck_req), 0);
    chk("hold_state", int'(state_o), 2);

    hold_b = 5'b00101; cyc(1); hold_b = 5'b00001; cyc(1); hold_b = 5'd0;
    chk("hold0", int'(hold_o0), 0);
    chk("hold2", int'(hold_o2), 1);
    chk("hold1", int'(hold_o1), 0);

    draw_b = 1'b1; cyc(1); draw_b = 1'b0;
    chk("draw_rise", int'(draw_s), 1);
    hold_b = 5'b11111; cyc(1); hold_b = 5'd0;
    cyc(2);
    chk("draw_held", int'(draw_s), 1);
    chk("hold_frozen", int'({hold_o4, hold_o3, hold_o2, hold_o1, hold_o0}), 4);
    pjudge = 1'b1; cyc(1); pjudge = 1'b0;
    chk("draw_fall", int'(draw_s), 0);
    chk("judge_state", int'(state_o), 4);

    hand_rank = 4'd6; rank_valid = 1'b1; cyc(1); rank_valid = 1'b0;
    chk("payout_state", int'(state_o), 5);
    cyc(1);
    chk("fh_win", int'(win), 10);
    chk("fh_credit", int'(credit), 109);
    chk("fh_idle", int'(state_o), 0);

    play_game(12, 5'b10000);
    chk("r12_win", int'(win), 0);
    chk("r12_credit", int'(credit), 108);
    chk("hold_with_draw", int'(hold_o4), 1);

    start_b = 1'b1; cyc(1); start_b = 1'b0;
    deck_ready = 1'b1; cyc(1); deck_ready = 1'b0;
    n = 0;
    while (draw_s !== 1'b1 && n < 100) begin cyc(1); n++; end
    chk("hold_timeout_cycles", n, HT);
    pjudge = 1'b1; cyc(1); pjudge = 1'b0;
    n = 0;
    while (state_o !== 3'd0 && n < 50) begin cyc(1); n++; end
    chk("judge_timeout_idle", int'(state_o), 0);
    chk("judge_timeout_win", int'(win), 0);
    chk("judge_timeout_credit", int'(credit), 107);

    n = 0;
    while (m_credit > 0 && n < 200) begin play_game(0, 5'd0); n++; end
    chk("drain_credit", int'(credit), 0);
    start_b = 1'b1; cyc(1); start_b = 1'b0;
    chk("lock_req", int'(deck_req), 0);
    chk("lock_state", int'(state_o), 0);

    do_reset();
    start_b = 1'b1; cyc(1); start_b = 1'b0;
    deck_ready = 1'b1; cyc(1); deck_ready = 1'b0;
    draw_b = 1'b1; cyc(1); draw_b = 1'b0;
    chk("pre_rst_draw", int'(draw_s), 1);
    #2 reset_c = 1'b0;
    #1;
    chk("async_draw_drop", int'(draw_s), 0);
    chk("async_credit", int'(credit), 100);
    chk("async_state", int'(state_o), 0);
    cyc(1); reset_c = 1'b1; cyc(1);

    n = 0;
    while (m_credit < 16'hFFF0 && n < 2000) begin
      if (m_credit + 99 <= 16'hFFF0) play_game(9, 5'd0);
      else play_game(3, 5'd0);
      n++;
    end
    chk("climb_credit", int'(credit), 16'hFFF0);
    play_game(9, 5'd0);
    chk("sat_win", int'(win), 100);
    chk("sat_credit", int'(credit), 16'hFFFF);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/poker_game_seq.md
Name: poker_game_seq

Overview:
- Top-level game controller for the poker datapath. Takes credit and bet, and requests a 10-card deal from the shuffler.
- Collects per-card hold toggles from the player and fires the draw step (hold_o0..4, draw_s). It then waits for the draw step to finish (pjudge) and for the hand evaluator's rank.
- Applies the payout to the credit register. Sits between the button/debounce front end and the draw, judge and display blocks.

Parameters:
- BET, 16'd1, credits deducted per game.
- INIT_CREDIT, 16'd100, credit value loaded at reset.
- HOLD_TIMEOUT, 24'd12_000_000, cycles in HOLD before an automatic draw. 0 disables the timeout.
- JUDGE_TIMEOUT, 8'd255, maximum cycles to wait for rank_valid. On expiry, payout is 0.

Ports:
- clock  in  1  system clock, rising edge
- reset_c  in  1  asynchronous active-low reset
- start_b  in  1  one-cycle pulse: bet and deal
- hold_b  in  5  one-cycle pulses: bit i toggles hold on card i
- draw_b  in  1  one-cycle pulse: execute draw
- deck_ready  in  1  shuffler has 10 valid cards on Pnum0..9/suit0..9
- pjudge  in  1  draw step complete; final hand valid on nnum/nsuit
- hand_rank  in  4  evaluator rank code, qualified by rank_valid
- rank_valid  in  1  hand_rank valid
- deck_req  out  1  request a new shuffle/deal
- hold_o0..hold_o4  out  1 each  hold flags driven to the draw step
- draw_s  out  1  draw command
- credit  out  16  current credit
- win  out  16  payout of the last game
- state_o  out  3  state code for display
- busy  out  1  high in every state except IDLE and HOLD

Behaviour:
- Reset (async, reset_c low):
  - state = IDLE, credit = INIT_CREDIT, win = 0.
  - All hold_o = 0, draw_s = 0, deck_req = 0, timers cleared.
- States and codes: IDLE 0, DEAL 1, HOLD 2, DRAW 3, JUDGE 4, PAYOUT 5.
- IDLE:
  - If start_b = 1 and credit ≥ BET: credit -= BET, win = 0, all hold_o = 0, deck_req = 1, go to DEAL.
  - If start_b = 1 and credit < BET: start_b is ignored and the state stays IDLE.
- DEAL:
  - deck_req is held at 1 until deck_ready = 1.
  - In the cycle deck_ready is seen: deck_req = 0, hold timer = 0, go to HOLD.
  - A deck_ready already high on entry advances on the first DEAL cycle (minimum DEAL dwell is 1 cycle).
- HOLD:
  - Each hold_b[i] pulse inverts hold_o{i} on the next edge. Several bits in the same cycle each toggle.
  - draw_b = 1, or the timer reaching HOLD_TIMEOUT-1 (when HOLD_TIMEOUT ≠ 0), goes to DRAW.
  - A hold_b pulse in the same cycle as draw_b is applied before the draw.
  - hold_b outside HOLD is ignored. start_b outside IDLE is ignored. draw_b outside HOLD is ignored.
- DRAW:
  - draw_s = 1 registered on DRAW entry, held until pjudge = 1 is sampled.
  - That cycle: draw_s = 0, judge timer = 0, go to JUDGE.
  - hold_o values are frozen from DRAW entry until the next IDLE start.
- JUDGE:
  - rank_valid = 1: latch hand_rank, go to PAYOUT.
  - Judge timer reaching JUDGE_TIMEOUT: latch rank 0, go to PAYOUT.
- PAYOUT (single cycle):
  - win = BET × mult(rank), truncated to 16 bits. credit = min(credit + win, 16'hFFFF), computed in 17 bits and saturated.
  - Go to IDLE.
  - mult table: 0→0, 1 (one pair)→0, 2 (two pair)→1, 3 (three)→2, 4 (straight)→3, 5 (flush)→4, 6 (full house)→10, 7 (four)→20, 8 (straight flush)→50, 9 (royal)→100, 10..15→0.
- Credit changes only on IDLE start (decrement) and in PAYOUT (increment). credit = 0 with BET > 0 locks the game in IDLE until reset.
- Reset mid-operation: all state is reinitialised immediately. A pending draw_s or deck_req drops asynchronously.
- Latency, start_b to deck_req: 1 cycle. pjudge to draw_s low: 1 cycle. rank_valid to credit update: 2 cycles.

Test Plan:
- Reset, INIT_CREDIT = 100 → credit = 100, state_o = 0, all outputs 0. Pulse start_b → next cycle credit = 99, deck_req = 1, state_o = 1. deck_ready high 3 cycles later → deck_req low, state_o = 2.
- In HOLD, pulse hold_b = 5'b00101, then 5'b00001 → hold_o0 = 0, hold_o2 = 1. Pulse draw_b → draw_s = 1. Delay pjudge 4 cycles → draw_s stays 1 until pjudge, then 0 next cycle.
- rank_valid with hand_rank = 6, BET = 1 → win = 10, credit 99 → 109, then state_o = 0. hand_rank = 12 → win = 0.
- credit = 16'hFFF0, BET = 1, rank 9 → credit saturates at 16'hFFFF.
- HOLD_TIMEOUT = 20, no draw_b → draw_s rises 20 cycles after HOLD entry. Separately, rank_valid never asserted with JUDGE_TIMEOUT = 8 → win = 0, return to IDLE.
- Case A: credit = 0, start_b pulse → no deck_req, state stays 0. Case B: reset_c low during DRAW → draw_s drops immediately, credit = INIT_CREDIT.
